// File: rtl/counter_if.sv
// Status bundle driven by the counter timebase.
// Optional parity signal present only when COUNTER_PARITY_EN is defined.
interface counter_if #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned WRAPS_WIDTH = 8
);
    logic [WIDTH-1:0]       count;
    logic [WIDTH-1:0]       count_gray;
    logic                   tc;
    logic                   wrap;
    logic [WRAPS_WIDTH-1:0] wraps;
`ifdef COUNTER_PARITY_EN
    logic                   parity;
`endif

    modport master (
        output count,
        output count_gray,
        output tc,
        output wrap,
`ifdef COUNTER_PARITY_EN
        output parity,
`endif
        output wraps
    );

    modport slave (
        input count,
        input count_gray,
        input tc,
        input wrap,
`ifdef COUNTER_PARITY_EN
        input parity,
`endif
        input wraps
    );
endinterface

// File: rtl/counter.sv
// Free-running modulo up-counter used as a timebase / event sequencer.
// Wraps to 0 after MAX_VALUE, pulses wrap on the cycle after each wrap and
// keeps a saturating count of wraps since reset.
// Optional feature: define COUNTER_PARITY_EN to add a registered even-parity
// output that always equals ^count.
module counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MAX_VALUE   = 2**WIDTH-1,
    parameter int unsigned WRAPS_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,      // asynchronous, active-low
    counter_if.master cnt_bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   tc;
    logic                   wrap_q;
    logic [WRAPS_WIDTH-1:0] wraps_q;

    assign tc = (count_q == MAX_V);

    // Next count: wrap to zero at the terminal value, otherwise increment.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (tc) begin
            count_d = '0;
        end
    end

    // Count, wrap pulse and saturating wrap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= tc;
            if (tc && (wraps_q != '1)) begin
                wraps_q <= wraps_q + WRAPS_WIDTH'(1);
            end
        end
    end

`ifdef COUNTER_PARITY_EN
    logic parity_q;

    // Parity is taken from the next count so it lands together with count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^count_d;
        end
    end

    assign cnt_bus.parity = parity_q;
`endif

    assign cnt_bus.count      = count_q;
    assign cnt_bus.count_gray = count_q ^ (count_q >> 1);
    assign cnt_bus.tc         = tc;
    assign cnt_bus.wrap       = wrap_q;
    assign cnt_bus.wraps      = wraps_q;
endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: three instances (default, MAX_VALUE=9,
// WIDTH=2/WRAPS_WIDTH=2) share clock and reset. Stimulus pushes the expected
// state for each cycle; the monitor samples on clock falling edges and right
// after an asynchronous reset assertion.
module tb_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    counter_if #(.WIDTH(4), .WRAPS_WIDTH(8)) if0 ();
    counter_if #(.WIDTH(4), .WRAPS_WIDTH(8)) if1 ();
    counter_if #(.WIDTH(2), .WRAPS_WIDTH(2)) if2 ();

    counter #(.WIDTH(4), .MAX_VALUE(15), .WRAPS_WIDTH(8)) u0 (.clk(clk), .rst(rst), .cnt_bus(if0));
    counter #(.WIDTH(4), .MAX_VALUE(9),  .WRAPS_WIDTH(8)) u1 (.clk(clk), .rst(rst), .cnt_bus(if1));
    counter #(.WIDTH(2), .MAX_VALUE(3),  .WRAPS_WIDTH(2)) u2 (.clk(clk), .rst(rst), .cnt_bus(if2));

    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic       wrap;
        logic [7:0] wraps;
    } dexp_t;

    typedef struct packed {
        dexp_t d2;
        dexp_t d1;
        dexp_t d0;
    } exp_t;

    exp_t q[$];
    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Expected state n edges after reset release for modulus m+1 and wrap
    // counter saturating at sat.
    function automatic dexp_t model(int unsigned n, int unsigned m, int unsigned sat);
        dexp_t d;
        int unsigned c;
        int unsigned w;
        c       = n % (m + 1);
        w       = n / (m + 1);
        d.cnt   = 8'(c);
        d.tc    = (c == m);
        d.wrap  = (n > 0) && (c == 0);
        d.wraps = 8'((w > sat) ? sat : w);
        return d;
    endfunction

    function automatic void push(int unsigned n);
        exp_t e;
        e.d0 = model(n, 15, 255);
        e.d1 = model(n, 9, 255);
        e.d2 = model(n, 3, 3);
        q.push_back(e);
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input dexp_t d,
                       input int unsigned cnt, input int unsigned gray,
                       input int unsigned tc, input int unsigned wrap,
                       input int unsigned wraps, input int unsigned par);
        int unsigned ec;
        ec = int'(d.cnt);
        chk({tag, ".count"}, cnt, ec);
        chk({tag, ".count_gray"}, gray, ec ^ (ec >> 1));
        chk({tag, ".tc"}, tc, int'(d.tc));
        chk({tag, ".wrap"}, wrap, int'(d.wrap));
        chk({tag, ".wraps"}, wraps, int'(d.wraps));
`ifdef COUNTER_PARITY_EN
        chk({tag, ".parity"}, par, int'(^d.cnt));
`else
        if (par != 0) begin
            chk({tag, ".parity_tie"}, par, 0);
        end
`endif
    endtask

    // Monitor: sample mid-low phase and just after reset assertion.
    initial begin
        exp_t e;
        int unsigned p0, p1, p2;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
`ifdef COUNTER_PARITY_EN
                p0 = int'(if0.parity);
                p1 = int'(if1.parity);
                p2 = int'(if2.parity);
`else
                p0 = 0;
                p1 = 0;
                p2 = 0;
`endif
                cmp("m15", e.d0, int'(if0.count), int'(if0.count_gray), int'(if0.tc),
                    int'(if0.wrap), int'(if0.wraps), p0);
                cmp("m9", e.d1, int'(if1.count), int'(if1.count_gray), int'(if1.tc),
                    int'(if1.wrap), int'(if1.wraps), p1);
                cmp("sat", e.d2, int'(if2.count), int'(if2.count_gray), int'(if2.tc),
                    int'(if2.wrap), int'(if2.wraps), p2);
            end
        end
    end

    // Stimulus.
    initial begin
        // Reset held across two clock edges.
        repeat (2) begin
            @(posedge clk);
            #1;
            push(0);
        end
        rst = 1'b1;

        // Free run: 39 edges leaves the default instance at count 7.
        for (int k = 1; k <= 39; k++) begin
            @(posedge clk);
            #1;
            push(k);
        end

        // Asynchronous reset between edges, checked immediately.
        @(negedge clk);
        #3;
        push(0);
        rst = 1'b0;

        // Held through one edge, then released; counting restarts 1,2,3.
        @(posedge clk);
        #1;
        push(0);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            push(k);
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        #2;
        chk("scoreboard_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/counter.md
Name: counter

Overview:
- Free-running, parameterized modulo up-counter with status outputs. No control inputs beyond clock and reset.
- Used as a timebase / event sequencer: increments every clock, wraps at a programmable terminal value, and flags each wrap.
- Single clock domain; all outputs registered or decoded directly from registers.

Parameters:
- WIDTH, 4, bit width of count.
- MAX_VALUE, 2**WIDTH-1, terminal value; count wraps to 0 after it. Legal range 1..2**WIDTH-1.
- WRAPS_WIDTH, 8, width of the saturating wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: rst=0 resets, rst=1 runs.
- count  output  WIDTH  current count value, registered.
- count_gray  output  WIDTH  Gray-code encoding of count: count ^ (count>>1), combinational from the count register.
- tc  output  1  terminal count, high while count==MAX_VALUE, combinational from the register.
- wrap  output  1  registered one-cycle pulse, high in the cycle after count goes from MAX_VALUE to 0.
- wraps  output  WRAPS_WIDTH  number of wraps since reset, saturating.

Behaviour:
- Reset: rst falling to 0 immediately, without waiting for a clock edge, forces:
  - count=0, wrap=0, wraps=0.
  - Derived outputs: tc=0 (given MAX_VALUE≥1) and count_gray=0.
- Reset is held while rst=0. Release is sampled on clk rising edges; the first increment happens on the first rising edge with rst=1.
- Each rising edge with rst=1:
  - If count==MAX_VALUE, count<=0, else count<=count+1.
  - Arithmetic is unsigned, WIDTH bits.
  - With MAX_VALUE=2**WIDTH-1 this is natural binary rollover, e.g. 4'hF -> 4'h0.
- tc is asserted for exactly one cycle per period of MAX_VALUE+1 cycles.
- wrap <= tc each edge. wrap is therefore high exactly during the cycle where count==0 following a wrap. It is never high in the first count==0 cycle after reset.
- wraps increments by 1 on each edge where tc=1, and saturates at all-ones (2**WRAPS_WIDTH-1) with no rollover.
- Reset mid-count: all registers return to reset values asynchronously, regardless of clock phase. No partial state is retained.
- count_gray changes exactly one bit per increment, except at a MAX_VALUE -> 0 wrap when MAX_VALUE≠2**WIDTH-1.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: COUNTER_PARITY_EN.
- Defined:
  - Adds output parity (1 bit), the registered even-parity bit of the next count value. It is updated alongside count, so parity == ^count at all times.
  - Reset value of parity is 0.
- Undefined: the parity port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset hold: rst=0 for 10 ns with clk toggling every 5 ns -> count=0, tc=0, wrap=0, wraps=0 throughout.
- Free run, default params: release rst, run 200 ns (20 edges) ->
  - count steps 0,1,...,15,0,1,2,3 on successive edges.
  - tc high only when count=15.
  - wrap high for one cycle at the count=0 following 15.
  - wraps=1.
- Async reset mid-run: drive rst=0 between clock edges while count=7 -> count=0, wraps=0 immediately. After release, counting restarts 1,2,3.
- MAX_VALUE=9 instance: sequence 0..9,0 repeats every 10 cycles. tc high at 9. wraps=3 after 30 edges from release.
- Saturation, WRAPS_WIDTH=2, WIDTH=2: run 40 edges -> wraps rises 1,2,3 then holds at 3.
- Gray/parity check: over 16 consecutive cycles, count_gray == count^(count>>1) every cycle. With COUNTER_PARITY_EN defined, parity == ^count every cycle, e.g. count=3 -> parity=0, count=7 -> parity=1.
